zombie_row_nearest_scanner: RTL and testbench
=============================================

Name: zombie_row_nearest_scanner

Overview:
- Per-lane frontmost-zombie finder. Successor to the combinational per-row stop calculator.
- Parametrised in zombie count, lane count, coordinate width and lane geometry.
- Scans the zombie table sequentially, one entry per clock, on each frame tick, then commits results atomically.
- Outputs, per lane: nearest (minimum) live zombie X, a lane-occupied flag and a live count. These feed pea-stop and plant-attack logic.

Parameters:
- N_ZOM, 10, number of zombie slots scanned.
- N_ROW, 5, number of lanes.
- W, 10, coordinate width in bits.
- ROW_BASE, 110, Y centre of lane 0.
- ROW_PITCH, 70, Y spacing between lanes. Lane r is centred at ROW_BASE + r*ROW_PITCH.
- NO_ZOM_X, all ones (1023), stop_x value for an empty lane.

Ports:
- MAX10_CLK1_50  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  single-cycle scan request.
- zom_x  in  N_ZOM*W  packed zombie centre X; slot i at bits [i*W +: W].
- zom_y  in  N_ZOM*W  packed zombie centre Y, same packing as zom_x.
- zom_live  in  N_ZOM  per-slot live flag.
- stop_x  out  N_ROW*W  per-lane minimum live X; lane r at bits [r*W +: W].
- row_valid  out  N_ROW  lane has at least one live zombie.
- row_count  out  N_ROW*CW  live zombies per lane, where CW = clog2(N_ZOM+1).
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when outputs are updated.
- overrun  out  1  sticky flag: a tick arrived while a pending tick was already queued.

Behaviour:
- Reset (async assert, sync release):
  - stop_x = NO_ZOM_X for every lane.
  - row_valid = 0, row_count = 0.
  - busy = 0, done = 0, overrun = 0, pending = 0.
  - FSM = IDLE.
  - A reset mid-scan discards all partial results.
- FSM has three states: IDLE, SCAN, COMMIT.
- IDLE:
  - frame_tick high at edge k → SCAN.
  - At the same edge: snapshot zom_x, zom_y, zom_live into internal registers; idx = 0; accumulators set to min = NO_ZOM_X, valid = 0, count = 0.
  - busy = 1 from k onward.
- SCAN:
  - Edge k+1+i processes snapshot slot i, for i = 0..N_ZOM-1.
  - If the slot is live and its Y equals a lane centre exactly, that lane's count increments and valid is set.
  - That lane's min is replaced only if X < min (strict unsigned compare). On equal X the lower slot index wins.
  - A Y matching no lane centre is ignored.
  - After slot N_ZOM-1 → COMMIT.
  - Input changes during SCAN have no effect; only the snapshot is used.
- COMMIT:
  - At the next edge, accumulators are copied to stop_x, row_valid and row_count in the same cycle, and done = 1 for exactly that one cycle.
  - If pending = 1: clear pending, re-snapshot, go to SCAN; busy stays 1.
  - Otherwise go to IDLE with busy = 0.
- Latency: the tick at edge k produces outputs at edge k+N_ZOM+1.
- Back-to-back throughput: one scan every N_ZOM+1 cycles.
- Ticks outside IDLE:
  - frame_tick while busy sets pending.
  - A tick while pending is already 1 sets overrun. overrun clears only on reset.
  - A tick on the COMMIT edge counts as pending.
- Outputs hold their last committed values between commits and never show partial scans.
- Arithmetic:
  - Lane centre comparisons use precomputed W-bit constants.
  - Counts never overflow, because CW covers N_ZOM.
- An empty lane commits stop_x = NO_ZOM_X and row_valid = 0.

Decomposition:
- Shared package (game_pkg):
  - ROW_BASE, ROW_PITCH, N_ROW, N_ZOM, W defaults.
  - NO_ZOM_X.
  - FSM state enum.
  - Function row_of(y) returning {hit, index}.
- One natural sub-module, lane_accumulator:
  - Holds one lane's min, valid and count, with clear/update ports.
  - Instantiated N_ROW times via generate.
- The top level holds the FSM, the snapshot registers, the index counter and the output registers.

Test Plan:
- Reset mid-scan: tick, then Reset_n low at cycle 4 → all stop_x = 1023, row_valid = 0, busy = 0, no done pulse afterwards.
- Single zombie: slot 3 live, X = 400, Y = 250; tick → exactly 11 cycles later done = 1; lane 2 stop_x = 400, row_count = 1, row_valid = 00100; other lanes 1023.
- Minimum and tie: lane 0 has X = 500 (slot 0), X = 300 (slot 5), X = 300 (slot 7) → stop_x[0] = 300, row_count[0] = 3. Slot 0 arriving first with the larger X must still lose.
- Dead and off-grid: slot 1 has live = 0, Y = 110, X = 50; slot 2 has live = 1, Y = 111 → lane 0 remains 1023 / valid 0.
- Snapshot isolation: change zom_x of a live slot during SCAN → the committed value equals the pre-tick value.
- Tick during scan: a second tick mid-scan → two done pulses 11 cycles apart, overrun = 0. A third tick before the first commit → overrun = 1 and it stays 1.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the zombie lane scanner.
//   - Default table and lane geometry (N_ZOM, N_ROW, W, ROW_BASE, ROW_PITCH).
//   - NO_ZOM_X: stop_x value reported for a lane with no live zombie.
//   - scan_state_t: scanner FSM states.
//   - row_of(): maps a Y coordinate to the lane whose centre it equals.
// ---------------------------------------------------------------------------
package game_pkg;

   localparam int N_ZOM     = 10;
   localparam int N_ROW     = 5;
   localparam int W         = 10;
   localparam int ROW_BASE  = 110;
   localparam int ROW_PITCH = 70;

   localparam logic [W-1:0] NO_ZOM_X = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_COMMIT
   } scan_state_t;

   typedef struct packed {
      logic       hit;
      logic [7:0] idx;
   } row_hit_t;

   // Lane centres are truncated to w bits so the compare matches what a
   // w-bit coordinate register can actually hold. Called with constant
   // geometry, so the loop unrolls into N_ROW constant comparators.
   function automatic row_hit_t row_of(input logic [31:0] y,
                                       input int          base,
                                       input int          pitch,
                                       input int          n_row,
                                       input int          w);
      row_hit_t    res;
      logic [31:0] mask;
      logic [31:0] centre;
      res  = '0;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      for (int r = 0; r < n_row; r++) begin
         centre = 32'(base + r * pitch) & mask;
         if (!res.hit && (centre == (y & mask))) begin
            res.hit = 1'b1;
            res.idx = 8'(r);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/lane_accumulator.sv
// ---------------------------------------------------------------------------
// lane_accumulator
// Running minimum X, occupancy flag and live count for one lane during a
// table scan.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart accumulation (min = NO_ZOM_X, valid = 0, count = 0)
//   update      a live zombie in this lane is presented on x this cycle
//   x           zombie X coordinate
//   min_x       smallest X seen since clear
//   valid       at least one update since clear
//   count       number of updates since clear
// ---------------------------------------------------------------------------
module lane_accumulator #(
   parameter int           W        = 10,
   parameter int           CW       = 4,
   parameter logic [W-1:0] NO_ZOM_X = '1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          update,
   input  logic [W-1:0]  x,
   output logic [W-1:0]  min_x,
   output logic          valid,
   output logic [CW-1:0] count
);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_x <= NO_ZOM_X;
         valid <= 1'b0;
         count <= '0;
      end else if (clear) begin
         min_x <= NO_ZOM_X;
         valid <= 1'b0;
         count <= '0;
      end else if (update) begin
         valid <= 1'b1;
         count <= count + CW'(1);
         // Strict compare: slots arrive in index order, so on equal X the
         // earlier (lower-index) slot keeps the minimum.
         if (x < min_x) begin
            min_x <= x;
         end
      end
   end

endmodule

// File: rtl/zombie_row_nearest_scanner.sv
// ---------------------------------------------------------------------------
// zombie_row_nearest_scanner
// On each frame tick, snapshots the zombie table and walks it one slot per
// clock, then commits per-lane nearest X / occupancy / count atomically.
//   MAX10_CLK1_50  system clock
//   Reset_n        asynchronous active-low reset
//   frame_tick     single-cycle scan request
//   zom_x, zom_y   packed zombie centres, slot i at [i*W +: W]
//   zom_live       per-slot live flag
//   stop_x         per-lane minimum live X, lane r at [r*W +: W]
//   row_valid      lane has at least one live zombie
//   row_count      live zombies per lane, lane r at [r*CW +: CW]
//   busy           scan or commit in progress
//   done           one-cycle pulse when outputs are updated
//   overrun        sticky: a tick arrived while another was already queued
// ---------------------------------------------------------------------------
module zombie_row_nearest_scanner #(
   parameter int           N_ZOM     = game_pkg::N_ZOM,
   parameter int           N_ROW     = game_pkg::N_ROW,
   parameter int           W         = game_pkg::W,
   parameter int           ROW_BASE  = game_pkg::ROW_BASE,
   parameter int           ROW_PITCH = game_pkg::ROW_PITCH,
   parameter logic [W-1:0] NO_ZOM_X  = '1,
   localparam int          CW        = $clog2(N_ZOM + 1)
) (
   input  logic                MAX10_CLK1_50,
   input  logic                Reset_n,
   input  logic                frame_tick,
   input  logic [N_ZOM*W-1:0]  zom_x,
   input  logic [N_ZOM*W-1:0]  zom_y,
   input  logic [N_ZOM-1:0]    zom_live,
   output logic [N_ROW*W-1:0]  stop_x,
   output logic [N_ROW-1:0]    row_valid,
   output logic [N_ROW*CW-1:0] row_count,
   output logic                busy,
   output logic                done,
   output logic                overrun
);

   import game_pkg::*;

   localparam int             IW       = (N_ZOM > 1) ? $clog2(N_ZOM) : 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(N_ZOM - 1);

   scan_state_t      state, state_next;
   logic             start_scan;
   logic             do_commit;
   logic [IW-1:0]    idx;
   logic             pending;

   logic [W-1:0]     snap_x [N_ZOM];
   logic [W-1:0]     snap_y [N_ZOM];
   logic [N_ZOM-1:0] snap_live;

   row_hit_t         slot_hit;
   logic             scan_live;
   logic [N_ROW-1:0] lane_upd;

   logic [W-1:0]     acc_min   [N_ROW];
   logic             acc_valid [N_ROW];
   logic [CW-1:0]    acc_count [N_ROW];

   // ---------------- FSM ----------------
   always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      start_scan = 1'b0;
      do_commit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frame_tick) begin
               start_scan = 1'b1;
               state_next = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (idx == LAST_IDX) begin
               state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            do_commit = 1'b1;
            // A tick landing on the commit edge is served immediately, as if
            // it had been queued, so back-to-back scans lose no cycle.
            if (pending || frame_tick) begin
               start_scan = 1'b1;
               state_next = ST_SCAN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   // ---------------- tick queue ----------------
   always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            ST_SCAN: begin
               if (frame_tick) begin
                  if (pending) begin
                     overrun <= 1'b1;
                  end else begin
                     pending <= 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               // The queued tick is consumed by the restart; a fresh tick on
               // this edge becomes the new queued one and flags the overrun.
               if (pending) begin
                  pending <= frame_tick;
                  if (frame_tick) begin
                     overrun <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- slot index ----------------
   always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         idx <= '0;
      end else if (start_scan) begin
         idx <= '0;
      end else if (state == ST_SCAN) begin
         idx <= idx + IW'(1);
      end
   end

   // ---------------- snapshot ----------------
   // NOTE: the snapshot is a plain data store with no reset; it is always
   // written by start_scan before the FSM reads any of it.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (start_scan) begin
         for (int i = 0; i < N_ZOM; i++) begin
            snap_x[i] <= zom_x[i*W +: W];
            snap_y[i] <= zom_y[i*W +: W];
         end
         snap_live <= zom_live;
      end
   end

   // ---------------- per-lane accumulation ----------------
   assign slot_hit  = row_of(32'(snap_y[idx]), ROW_BASE, ROW_PITCH, N_ROW, W);
   assign scan_live = (state == ST_SCAN) && snap_live[idx];

   for (genvar r = 0; r < N_ROW; r++) begin : g_lane
      assign lane_upd[r] = scan_live && slot_hit.hit && (slot_hit.idx == 8'(r));

      lane_accumulator #(
         .W        (W),
         .CW       (CW),
         .NO_ZOM_X (NO_ZOM_X)
      ) u_acc (
         .clk    (MAX10_CLK1_50),
         .rst_n  (Reset_n),
         .clear  (start_scan),
         .update (lane_upd[r]),
         .x      (snap_x[idx]),
         .min_x  (acc_min[r]),
         .valid  (acc_valid[r]),
         .count  (acc_count[r])
      );
   end

   // ---------------- committed outputs ----------------
   always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
      if (!Reset_n) begin
         stop_x    <= {N_ROW{NO_ZOM_X}};
         row_valid <= '0;
         row_count <= '0;
         done      <= 1'b0;
      end else begin
         done <= do_commit;
         if (do_commit) begin
            for (int r = 0; r < N_ROW; r++) begin
               stop_x[r*W +: W]    <= acc_min[r];
               row_valid[r]        <= acc_valid[r];
               row_count[r*CW +: CW] <= acc_count[r];
            end
         end
      end
   end

endmodule

// File: tb/tb_zombie_row_nearest_scanner.sv
module tb_zombie_row_nearest_scanner;
   import game_pkg::*;

   localparam int NZ = 10;
   localparam int NR = 5;
   localparam int WW = 10;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              tick = 1'b0;
   logic [NZ*WW-1:0]  zx = '0;
   logic [NZ*WW-1:0]  zy = '0;
   logic [NZ-1:0]     zl = '0;
   logic [NR*WW-1:0]  stop_x;
   logic [NR-1:0]     row_valid;
   logic [NR*CW-1:0]  row_count;
   logic              busy, done, overrun;

   zombie_row_nearest_scanner dut (
      .MAX10_CLK1_50 (clk),
      .Reset_n       (rst_n),
      .frame_tick    (tick),
      .zom_x         (zx),
      .zom_y         (zy),
      .zom_live      (zl),
      .stop_x        (stop_x),
      .row_valid     (row_valid),
      .row_count     (row_count),
      .busy          (busy),
      .done          (done),
      .overrun       (overrun)
   );

   always #10 clk = ~clk;

   typedef struct {
      int               cyc;
      logic [NR*WW-1:0] sx;
      logic [NR-1:0]    rv;
      logic [NR*CW-1:0] rc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   edge_n = 0;
   int   done_seen = 0;
   int   total = 0;
   int   passed = 0;

   // Reference model of the tick/scan timeline
   bit   m_active = 0;
   bit   m_pend = 0;
   bit   m_ov = 0;
   int   m_commit = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                    name, act, act, exp, exp, edge_n);
   endtask

   always @(posedge clk) edge_n++;

   // Lane result straight from the rules: the smallest X among live slots
   // whose Y sits exactly on that lane's centre.
   function automatic exp_t ref_scan(input int commit_cyc);
      exp_t e;
      e.cyc = commit_cyc;
      for (int r = 0; r < NR; r++) begin
         int mn  = 1023;
         int cnt = 0;
         for (int i = 0; i < NZ; i++) begin
            if (zl[i] && int'(zy[i*WW +: WW]) == 110 + 70 * r) begin
               cnt++;
               if (int'(zx[i*WW +: WW]) < mn) mn = int'(zx[i*WW +: WW]);
            end
         end
         e.sx[r*WW +: WW] = WW'(mn);
         e.rv[r]          = (cnt > 0);
         e.rc[r*CW +: CW] = CW'(cnt);
      end
      return e;
   endfunction

   task automatic model_start(input int c);
      q.push_back(ref_scan(c + NZ + 1));
      m_active = 1;
      m_commit = c + NZ + 1;
   endtask

   // Advance the model across the coming rising edge with tick value t.
   task automatic model_edge(input bit t);
      int c;
      c = edge_n + 1;
      if (!m_active) begin
         if (t) model_start(c);
      end else if (c < m_commit) begin
         if (t) begin
            if (m_pend) m_ov = 1;
            else m_pend = 1;
         end
      end else begin
         if (m_pend) begin
            model_start(c);
            m_pend = t;
            if (t) m_ov = 1;
         end else if (t) begin
            model_start(c);
         end else begin
            m_active = 0;
         end
      end
   endtask

   task automatic step(input bit t);
      tick = t;
      model_edge(t);
      @(negedge clk);
      tick = 1'b0;
      check("busy", busy, m_active);
      check("overrun", overrun, m_ov);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic set_slot(input int i, input int x, input int y, input bit live);
      zx[i*WW +: WW] = WW'(x);
      zy[i*WW +: WW] = WW'(y);
      zl[i]          = live;
   endtask

   task automatic clear_slots();
      zx = '0;
      zy = '0;
      zl = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      m_active = 0;
      m_pend   = 0;
      m_ov     = 0;
      #1;
      check("rst_stop_x", stop_x, {NR{NO_ZOM_X}});
      check("rst_row_valid", row_valid, 0);
      check("rst_row_count", row_count, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every done pulse must match the oldest expected scan, on time.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            done_seen++;
            if (q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               mon_e = q.pop_front();
               check("done_cycle", edge_n, mon_e.cyc);
               check("stop_x", stop_x, mon_e.sx);
               check("row_valid", row_valid, mon_e.rv);
               check("row_count", row_count, mon_e.rc);
            end
         end else if (q.size() > 0 && q[0].cyc <= edge_n) begin
            mon_e = q.pop_front();
            check("missing_done", 0, 1);
         end
      end
   end

   initial begin
      int ds;
      @(negedge clk);
      do_reset();
      idle(2);

      // Single zombie in lane 2
      clear_slots();
      set_slot(3, 400, 250, 1);
      ds = done_seen;
      step(1'b1);
      idle(12);
      check("single_done_count", done_seen - ds, 1);
      check("single_lane2_x", stop_x[2*WW +: WW], 400);
      check("single_lane2_cnt", row_count[2*CW +: CW], 1);
      check("single_valid", row_valid, 5'b00100);
      check("single_lane0_x", stop_x[0 +: WW], 1023);

      // Minimum with tie, larger X arrives first
      clear_slots();
      set_slot(0, 500, 110, 1);
      set_slot(5, 300, 110, 1);
      set_slot(7, 300, 110, 1);
      step(1'b1);
      idle(12);
      check("tie_lane0_x", stop_x[0 +: WW], 300);
      check("tie_lane0_cnt", row_count[0 +: CW], 3);

      // Dead slot and off-grid Y
      clear_slots();
      set_slot(1, 50, 110, 0);
      set_slot(2, 60, 111, 1);
      step(1'b1);
      idle(12);
      check("offgrid_lane0_x", stop_x[0 +: WW], 1023);
      check("offgrid_lane0_v", row_valid[0], 0);

      // Snapshot isolation: X changes mid-scan
      clear_slots();
      set_slot(4, 200, 180, 1);
      step(1'b1);
      idle(3);
      set_slot(4, 10, 180, 1);
      idle(10);
      check("snap_lane1_x", stop_x[1*WW +: WW], 200);

      // Second tick mid-scan: two commits, no overrun
      clear_slots();
      set_slot(6, 77, 320, 1);
      ds = done_seen;
      step(1'b1);
      idle(4);
      step(1'b1);
      idle(25);
      check("b2b_done_count", done_seen - ds, 2);
      check("b2b_overrun", overrun, 0);

      // Third tick before the first commit: sticky overrun
      step(1'b1);
      idle(1);
      step(1'b1);
      idle(2);
      step(1'b1);
      idle(30);
      check("ovr_set", overrun, 1);
      idle(5);
      check("ovr_sticky", overrun, 1);

      // Reset mid-scan discards the scan
      clear_slots();
      set_slot(0, 5, 390, 1);
      step(1'b1);
      idle(3);
      do_reset();
      ds = done_seen;
      idle(15);
      check("rst_no_done", done_seen - ds, 0);
      check("rst_lane4_x", stop_x[4*WW +: WW], 1023);

      // Randomized traffic
      for (int i = 0; i < NZ; i++)
         set_slot(i, $urandom_range(1023), 110 + 70 * $urandom_range(NR - 1), $urandom_range(1));
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(3) == 0) begin
            int s;
            int y;
            s = $urandom_range(NZ - 1);
            y = ($urandom_range(3) == 0) ? $urandom_range(1023) : 110 + 70 * $urandom_range(NR - 1);
            set_slot(s, ($urandom_range(1) == 1) ? $urandom_range(1023) : $urandom_range(300, 303),
                     y, $urandom_range(3) != 0);
         end
         step($urandom_range(7) == 0);
      end

      // Drain outstanding scans with a bounded wait
      for (int c = 0; c < 40 && (q.size() > 0 || m_active); c++) step(1'b0);
      check("drain_empty", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
